// File: rtl/page_stream_rr_merge.sv
// rtl/page_stream_rr_merge.sv - four-input round-robin page stream merge with packet lock
// Tokens land in a one-entry output register tagged with their source index.
module page_stream_rr_merge #(
    parameter int W        = 16,
    parameter int MAXBURST = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] in0_d,
    input  logic [W-1:0] in1_d,
    input  logic [W-1:0] in2_d,
    input  logic [W-1:0] in3_d,
    input  logic [3:0]   in_e,
    input  logic [3:0]   in_v,
    output logic [3:0]   in_b,
    output logic [W-1:0] out_d,
    output logic [1:0]   out_tag,
    output logic         out_e,
    output logic         out_v,
    input  logic         out_b
);

    localparam logic       ST_IDLE = 1'b0;
    localparam logic       ST_LOCK = 1'b1;
    localparam logic [8:0] MB      = 9'(MAXBURST);

    logic         state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   owner_q, owner_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         out_v_q, out_v_d;
    logic [W-1:0] out_d_q, out_d_d;
    logic [1:0]   out_tag_q, out_tag_d;
    logic         out_e_q, out_e_d;

    logic [1:0]   grant;
    logic         grant_valid;
    logic [1:0]   idx;
    logic [W-1:0] sel_d;
    logic         sel_e;
    logic         can_load;
    logic         xfer;
    logic         release_cnt;

    // Search from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        grant       = ptr_q;
        grant_valid = 1'b0;
        idx         = ptr_q;
        if (state_q == ST_LOCK) begin
            grant       = owner_q;
            grant_valid = in_v[owner_q];
        end else begin
            for (int k = 3; k >= 0; k--) begin
                idx = ptr_q + 2'(k);
                if (in_v[idx]) begin
                    grant       = idx;
                    grant_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_d = in0_d;
        case (grant)
            2'd0: sel_d = in0_d;
            2'd1: sel_d = in1_d;
            2'd2: sel_d = in2_d;
            default: sel_d = in3_d;
        endcase
        sel_e = in_e[grant];
    end

    assign can_load = !out_v_q || !out_b;
    assign xfer     = can_load && grant_valid;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_b[i] = reset || !(xfer && (grant == 2'(i)));
        end
    end

    // cnt counts tokens already sent in this packet, so the limiting token sees cnt+1.
    assign release_cnt = (MAXBURST != 0) && (({1'b0, cnt_q} + 9'd1) == MB);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            if (state_q == ST_IDLE) begin
                if (sel_e || (MAXBURST == 1)) begin
                    ptr_d = grant + 2'd1;
                end else begin
                    state_d = ST_LOCK;
                    owner_d = grant;
                    cnt_d   = 8'd1;
                end
            end else begin
                if (sel_e || release_cnt) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_q + 2'd1;
                    cnt_d   = 8'd0;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        out_v_d   = out_v_q;
        out_d_d   = out_d_q;
        out_tag_d = out_tag_q;
        out_e_d   = out_e_q;
        if (can_load) begin
            out_v_d = xfer;
            if (xfer) begin
                out_d_d   = sel_d;
                out_tag_d = grant;
                out_e_d   = sel_e;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            owner_q   <= 2'd0;
            cnt_q     <= 8'd0;
            out_v_q   <= 1'b0;
            out_d_q   <= '0;
            out_tag_q <= 2'd0;
            out_e_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            out_v_q   <= out_v_d;
            out_d_q   <= out_d_d;
            out_tag_q <= out_tag_d;
            out_e_q   <= out_e_d;
        end
    end

    assign out_v   = out_v_q;
    assign out_d   = out_d_q;
    assign out_tag = out_tag_q;
    assign out_e   = out_e_q;

endmodule

// File: tb/tb_page_stream_rr_merge.sv
// tb/tb_page_stream_rr_merge.sv - randomized check of page_stream_rr_merge against a packet-level model
module tb_page_stream_rr_merge;

    localparam int W  = 16;
    localparam int MB = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] din [4];
    logic [3:0]   in_e, in_v, in_b;
    logic [W-1:0] out_d;
    logic [1:0]   out_tag;
    logic         out_e, out_v, out_b;

    int total = 0;
    int bad   = 0;

    // Model: which source holds a packet (-1 none), tokens in it so far, next round-robin start.
    int           locked, burst_n, rr;
    logic         m_v;
    logic [W-1:0] m_d;
    logic [1:0]   m_tag;
    logic         m_e;

    page_stream_rr_merge #(.W(W), .MAXBURST(MB)) dut (
        .clock  (clock),
        .reset  (reset),
        .in0_d  (din[0]),
        .in1_d  (din[1]),
        .in2_d  (din[2]),
        .in3_d  (din[3]),
        .in_e   (in_e),
        .in_v   (in_v),
        .in_b   (in_b),
        .out_d  (out_d),
        .out_tag(out_tag),
        .out_e  (out_e),
        .out_v  (out_v),
        .out_b  (out_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        locked  = -1;
        burst_n = 0;
        rr      = 0;
        m_v     = 1'b0;
        m_d     = '0;
        m_tag   = 2'd0;
        m_e     = 1'b0;
    endtask

    initial begin
        int   g;
        bit   gv;
        bit   xfer;
        bit   force_all;
        logic [3:0] exp_b;

        reset = 1'b1;
        in_v  = 4'b0;
        in_e  = 4'b0;
        out_b = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        model_reset();

        @(negedge clock);
        #1;
        chk("rst_out_v", 32'(out_v), 32'd0);
        chk("rst_in_b", 32'(in_b), 32'hF);
        chk("rst_out_d", 32'(out_d), 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_e", 32'(out_e), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        force_all = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            if (cyc == 1500) begin
                reset = 1'b1;
                #1;
                chk("midrst_out_v", 32'(out_v), 32'd0);
                chk("midrst_in_b", 32'(in_b), 32'hF);
                @(negedge clock);
                reset = 1'b0;
                model_reset();
                force_all = 1'b1;
            end

            for (int i = 0; i < 4; i++) begin
                in_v[i] = ($urandom_range(0, 9) < 7);
                in_e[i] = ($urandom_range(0, 9) == 0);
                din[i]  = W'($urandom);
            end
            if (cyc >= 600 && cyc < 900)
                out_b = ($urandom_range(0, 9) < 7);
            else
                out_b = ($urandom_range(0, 9) < 2);
            if (force_all) begin
                in_v = 4'hF;
                out_b = 1'b0;
                force_all = 1'b0;
            end

            #1;
            g  = 0;
            gv = 1'b0;
            if (locked >= 0) begin
                g  = locked;
                gv = in_v[locked];
            end else begin
                for (int k = 0; k < 4 && !gv; k++) begin
                    if (in_v[(rr + k) % 4]) begin
                        g  = (rr + k) % 4;
                        gv = 1'b1;
                    end
                end
            end
            xfer  = (!m_v || !out_b) && gv;
            exp_b = 4'hF;
            if (xfer) exp_b[g] = 1'b0;
            chk("in_b", 32'(in_b), 32'(exp_b));

            @(posedge clock);
            if (!m_v || !out_b) begin
                m_v = xfer;
                if (xfer) begin
                    m_d   = din[g];
                    m_tag = 2'(g);
                    m_e   = in_e[g];
                end
            end
            if (xfer) begin
                burst_n++;
                if (in_e[g] || (MB != 0 && burst_n == MB)) begin
                    locked  = -1;
                    burst_n = 0;
                    rr      = (g + 1) % 4;
                end else begin
                    locked = g;
                end
            end

            #1;
            chk("out_v", 32'(out_v), 32'(m_v));
            if (m_v) begin
                chk("out_d", 32'(out_d), 32'(m_d));
                chk("out_tag", 32'(out_tag), 32'(m_tag));
                chk("out_e", 32'(out_e), 32'(m_e));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
